// File: rtl/program_loader.sv
// program_loader
//   Boot loader sequencer for the writable program memory. A byte stream
//   (UART receiver or debug port) supplies a 16-bit big-endian word count N
//   followed by N 32-bit words, MSB first. Each word is written to program
//   memory in a single-cycle WRITE state. The CPU is held until the load
//   completes. The memory address is driven by the loader while the CPU is
//   held, and by the CPU fetch PC otherwise.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   start       one-cycle pulse that begins a load (honoured in IDLE/DONE/ERROR)
//   byte_valid  byte_data is valid this cycle
//   byte_data   incoming stream byte
//   byte_ready  loader accepts a byte this cycle (HDR0, HDR1, DATA)
//   pc_address  CPU fetch byte address
//   mem_addr    program memory word address
//   mem_we      program memory write strobe (WRITE only)
//   mem_wdata   word to write; holds its last value outside WRITE
//   cpu_hold    stall request to the CPU (low only in DONE)
//   load_done   last load completed
//   load_error  last load rejected (word count out of range)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset, waiting for start, CPU held
// HDR0  | waiting for word count high byte
// HDR1  | waiting for word count low byte, then range check
// DATA  | collecting the 4 bytes of the current word
// WRITE | one-cycle write of the assembled word at word_idx
// DONE  | load finished, CPU released, PC drives the memory address
// ERROR | header rejected, CPU stays held

module program_loader #(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic [DATA_WIDTH-1:0] pc_address,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [1:0]              byte_cnt;
    logic [15:0]             count;
    logic [DATA_WIDTH-9:0]   shift;

    logic                    accept;
    logic [15:0]             hdr_count;
    logic [15:0]             word_next;

    // Only the word-address bits of the PC select a memory word.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_address[DATA_WIDTH-1:ADDR_WIDTH+2], pc_address[1:0]};

    assign byte_ready = (state == HDR0) || (state == HDR1) || (state == DATA);
    assign mem_we     = (state == WRITE);
    assign cpu_hold   = (state != DONE);
    assign load_done  = (state == DONE);
    assign load_error = (state == ERROR);

    assign mem_addr   = cpu_hold ? word_idx : pc_address[ADDR_WIDTH+1:2];

    assign accept     = byte_valid && byte_ready;
    // Full count as it will be once the low header byte lands.
    assign hdr_count  = {count[15:8], byte_data};
    // Number of words written once the current WRITE completes.
    assign word_next  = 16'(word_idx) + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            word_idx  <= '0;
            byte_cnt  <= '0;
            count     <= '0;
            shift     <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state    <= HDR0;
                        word_idx <= '0;
                        byte_cnt <= '0;
                        count    <= '0;
                    end
                end
                HDR0: begin
                    if (accept) begin
                        count[15:8] <= byte_data;
                        state       <= HDR1;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        count[7:0] <= byte_data;
                        if (hdr_count == 16'd0)
                            state <= DONE;
                        else if (hdr_count > 16'(MEMORY_DEPTH))
                            state <= ERROR;
                        else
                            state <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        shift <= {shift[DATA_WIDTH-17:0], byte_data};
                        if (byte_cnt == 2'd3) begin
                            byte_cnt  <= 2'd0;
                            mem_wdata <= {shift, byte_data};
                            state     <= WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    if (word_next == count) begin
                        state <= DONE;
                    end else begin
                        word_idx <= word_idx + 1'b1;
                        state    <= DATA;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] pc_address;
    logic [4:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int errors = 0;
    int checks = 0;
    int writes_seen = 0;

    logic [4:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    always #5 clk = ~clk;

    program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .pc_address (pc_address),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            logic [4:0]  ea;
            logic [31:0] ed;
            writes_seen++;
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=%08h, none expected", mem_addr, mem_wdata);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (mem_addr !== ea || mem_wdata !== ed) begin
                    errors++;
                    $display("FAIL write_word: got addr=%0d data=%08h, expected addr=%0d data=%08h",
                             mem_addr, mem_wdata, ea, ed);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present a byte and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        forever begin
            @(negedge clk);
            if (byte_ready === 1'b1) begin
                @(posedge clk);
                #1;
                byte_valid = 1'b0;
                return;
            end
            n++;
            if (n > 50) begin
                errors++;
                checks++;
                $display("FAIL byte_timeout: byte_ready stayed %b, expected 1", byte_ready);
                byte_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic send_word(input logic [4:0] addr, input logic [31:0] w);
        exp_addr_q.push_back(addr);
        exp_data_q.push_back(w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        pc_address = 32'h0000_0008;
        repeat (3) tick();
        checks++;
        if ({cpu_hold, load_done, load_error, mem_we, byte_ready} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs: hold/done/err/we/ready=%b, expected 10000",
                     {cpu_hold, load_done, load_error, mem_we, byte_ready});
        end
        checks++;
        if (mem_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_mem_addr: got %0d, expected 0", mem_addr);
        end
    endtask

    task automatic test_basic_load();
        int w0;
        w0 = writes_seen;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(5'd0, 32'h2008_0005);
        send_word(5'd1, 32'h2009_0007);
        checks++;
        if (load_done !== 1'b0 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL basic_last_write_cycle: done=%b we=%b, expected done=0 we=1", load_done, mem_we);
        end
        tick();
        checks++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b hold=%b we=%b, expected 1 0 0", load_done, cpu_hold, mem_we);
        end
        checks++;
        if (writes_seen - w0 != 2 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL basic_write_count: got %0d writes, %0d pending, expected 2 and 0",
                     writes_seen - w0, exp_addr_q.size());
        end
    endtask

    task automatic test_pc_mux();
        pc_address = 32'h0000_0004;
        #1;
        checks++;
        if (mem_addr !== 5'd1) begin
            errors++;
            $display("FAIL pc_mux_4: got %0d, expected 1", mem_addr);
        end
        pc_address = 32'h0000_007C;
        #1;
        checks++;
        if (mem_addr !== 5'd31) begin
            errors++;
            $display("FAIL pc_mux_7c: got %0d, expected 31", mem_addr);
        end
        pc_address = 32'hFFFF_FF8B;
        #1;
        checks++;
        if (mem_addr !== 5'd2) begin
            errors++;
            $display("FAIL pc_mux_ignore_bits: got %0d, expected 2", mem_addr);
        end
        pc_address = 32'h0000_0008;
    endtask

    task automatic test_error_and_zero();
        int w0;
        w0 = writes_seen;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h21);
        tick();
        checks++;
        if ({load_error, load_done, cpu_hold, byte_ready} !== 4'b1010) begin
            errors++;
            $display("FAIL error_state: err/done/hold/ready=%b, expected 1010",
                     {load_error, load_done, cpu_hold, byte_ready});
        end
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        checks++;
        if ({load_error, load_done, cpu_hold} !== 3'b010) begin
            errors++;
            $display("FAIL zero_count: err/done/hold=%b, expected 010", {load_error, load_done, cpu_hold});
        end
        checks++;
        if (writes_seen != w0) begin
            errors++;
            $display("FAIL error_zero_writes: got %0d writes, expected 0", writes_seen - w0);
        end
    endtask

    task automatic test_full_load();
        int w0;
        logic [31:0] w;
        w0 = writes_seen;
        pulse_start();
        send_byte(8'h00);
        tick();
        send_byte(8'h20);
        tick();
        for (int a = 0; a < 32; a++) begin
            w = $urandom;
            exp_addr_q.push_back(5'(a));
            exp_data_q.push_back(w);
            for (int i = 3; i >= 0; i--) begin
                send_byte(w[8*i +: 8]);
                // Stray start while the load runs must be ignored.
                if (a == 10 && i == 1) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        repeat (2) tick();
        checks++;
        if (writes_seen - w0 != 32 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL full_write_count: got %0d writes, %0d pending, expected 32 and 0",
                     writes_seen - w0, exp_addr_q.size());
        end
        checks++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL full_done: done=%b hold=%b, expected 1 0", load_done, cpu_hold);
        end
    endtask

    task automatic test_reset_mid_load();
        int w0;
        w0 = writes_seen;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h03);
        send_word(5'd0, 32'hCAFE_F00D);
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({cpu_hold, mem_we, byte_ready, load_done, load_error} !== 5'b10000) begin
            errors++;
            $display("FAIL mid_reset_outputs: hold/we/ready/done/err=%b, expected 10000",
                     {cpu_hold, mem_we, byte_ready, load_done, load_error});
        end
        repeat (3) tick();
        checks++;
        if (writes_seen - w0 != 1 || exp_addr_q.size() != 0 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_writes: got %0d writes ready=%b, expected 1 writes ready=0",
                     writes_seen - w0, byte_ready);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        pc_address = 32'h0;
        test_reset();
        test_basic_load();
        test_pc_mux();
        test_error_and_zero();
        test_full_load();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
